// File: rtl/kb_event_decoder.sv
// PS/2 keyboard front-end: deserialises and checks PS/2 frames, buffers the
// received bytes in a small FIFO, strips E0/F0 prefixes into one key event
// per key action on a valid/ready handshake, and tracks the held key plus a
// count of distinct presses for the display logic.
module kb_event_decoder #(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             ps2_clk,
   input  logic             ps2_data,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [7:0]       evt_code,
   output logic             evt_ext,
   output logic             evt_break,
   output logic             key_down,
   output logic [7:0]       cur_code,
   output logic             cur_ext,
   output logic [CNT_W-1:0] press_cnt,
   output logic             overflow,
   output logic             parity_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic [2:0] {
      IDLE,
      EXT,
      BRK,
      EXT_BRK,
      EMIT
   } state_t;

   logic [2:0]       sync_q, sync_d;
   logic [1:0]       data_q, data_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [9:0]       shift_q, shift_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [7:0]       mem_q [FIFO_DEPTH];
   logic             overflow_q, overflow_d;
   logic             parity_err_q, parity_err_d;
   state_t           state_q, state_d;
   logic [7:0]       evt_code_q, evt_code_d;
   logic             evt_ext_q, evt_ext_d;
   logic             evt_break_q, evt_break_d;
   logic             key_down_q, key_down_d;
   logic [7:0]       cur_code_q, cur_code_d;
   logic             cur_ext_q, cur_ext_d;
   logic [CNT_W-1:0] press_cnt_q, press_cnt_d;

   logic        fall;
   logic        frame_done;
   logic        frame_good;
   logic [10:0] frame_bits;
   logic        push_req;
   logic        push;
   logic        pop;
   logic        fifo_empty;
   logic        fifo_full;
   logic [7:0]  head;
   logic        lat_ext;
   logic        lat_brk;
   logic        latch;
   logic        same_key;

   // Frame assembly: synchronise the PS/2 clock, shift in one bit per falling
   // edge, and judge the whole frame when its stop bit arrives.
   always_comb begin
      sync_d       = {sync_q[1:0], ps2_clk};
      data_d       = {data_q[0], ps2_data};
      fall         = sync_q[2] & ~sync_q[1];
      frame_bits   = {data_q[1], shift_q};
      frame_done   = fall && (bit_cnt_q == 4'd10);
      frame_good   = ~frame_bits[0] & frame_bits[10] & (^frame_bits[9:1]);
      push_req     = frame_done & frame_good;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      parity_err_d = parity_err_q | (frame_done & ~frame_good);
      if (frame_done) begin
         bit_cnt_d = 4'd0;
      end else if (fall) begin
         bit_cnt_d = bit_cnt_q + 4'd1;
         shift_d   = {data_q[1], shift_q[9:1]};
      end
   end

   // FIFO bookkeeping: a push into a full FIFO still succeeds when the parser
   // frees a slot in the same cycle; otherwise the byte is lost and flagged.
   always_comb begin
      fifo_empty = (wr_ptr_q == rd_ptr_q);
      fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      pop        = ~fifo_empty && (state_q != EMIT);
      push       = push_req && (~fifo_full || pop);
      head       = mem_q[rd_ptr_q[AW-1:0]];
      wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      overflow_d = overflow_q | (push_req & fifo_full & ~pop);
   end

   // Prefix parser and key tracker: prefixes only move the state, any other
   // byte becomes an event and updates the held-key view in the same cycle.
   always_comb begin
      state_d     = state_q;
      evt_code_d  = evt_code_q;
      evt_ext_d   = evt_ext_q;
      evt_break_d = evt_break_q;
      key_down_d  = key_down_q;
      cur_code_d  = cur_code_q;
      cur_ext_d   = cur_ext_q;
      press_cnt_d = press_cnt_q;
      latch       = 1'b0;
      lat_ext     = (state_q == EXT) || (state_q == EXT_BRK);
      lat_brk     = (state_q == BRK) || (state_q == EXT_BRK);
      same_key    = (cur_code_q == head) && (cur_ext_q == lat_ext);

      if (state_q == EMIT) begin
         if (evt_ready) begin
            state_d = IDLE;
         end
      end else if (pop) begin
         if (head == 8'hE0) begin
            state_d = EXT;
         end else if (head == 8'hF0) begin
            if (state_q == IDLE) begin
               state_d = BRK;
            end else if (state_q == EXT) begin
               state_d = EXT_BRK;
            end
         end else begin
            latch = 1'b1;
         end
      end

      if (latch) begin
         state_d     = EMIT;
         evt_code_d  = head;
         evt_ext_d   = lat_ext;
         evt_break_d = lat_brk;
         if (!lat_brk) begin
            if (!(key_down_q && same_key)) begin
               cur_code_d  = head;
               cur_ext_d   = lat_ext;
               key_down_d  = 1'b1;
               press_cnt_d = press_cnt_q + CNT_W'(1);
            end
         end else if (same_key) begin
            key_down_d = 1'b0;
         end
      end
   end

   // State registers; everything returns to its idle value on reset.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         sync_q       <= 3'b000;
         data_q       <= 2'b00;
         bit_cnt_q    <= 4'd0;
         shift_q      <= 10'd0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         overflow_q   <= 1'b0;
         parity_err_q <= 1'b0;
         state_q      <= IDLE;
         evt_code_q   <= 8'd0;
         evt_ext_q    <= 1'b0;
         evt_break_q  <= 1'b0;
         key_down_q   <= 1'b0;
         cur_code_q   <= 8'd0;
         cur_ext_q    <= 1'b0;
         press_cnt_q  <= '0;
      end else begin
         sync_q       <= sync_d;
         data_q       <= data_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         overflow_q   <= overflow_d;
         parity_err_q <= parity_err_d;
         state_q      <= state_d;
         evt_code_q   <= evt_code_d;
         evt_ext_q    <= evt_ext_d;
         evt_break_q  <= evt_break_d;
         key_down_q   <= key_down_d;
         cur_code_q   <= cur_code_d;
         cur_ext_q    <= cur_ext_d;
         press_cnt_q  <= press_cnt_d;
      end
   end

   // FIFO storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= frame_bits[8:1];
      end
   end

   assign evt_valid  = (state_q == EMIT);
   assign evt_code   = evt_code_q;
   assign evt_ext    = evt_ext_q;
   assign evt_break  = evt_break_q;
   assign key_down   = key_down_q;
   assign cur_code   = cur_code_q;
   assign cur_ext    = cur_ext_q;
   assign press_cnt  = press_cnt_q;
   assign overflow   = overflow_q;
   assign parity_err = parity_err_q;

endmodule
